// File: rtl/keypad_lock_ctrl.sv
// Keypad lock controller: collects a CODE_LEN-digit code and compares it only once the code is
// complete. Adds a timed unlock window, lockout after repeated failures, and passcode reprogramming.
module keypad_lock_ctrl #(
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned UNLOCK_CYCLES  = 5,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] key_i,
    input  logic       key_valid_i,
    output logic       unlocked_o,
    output logic       lockout_o,
    output logic       fail_o,
    output logic       prog_mode_o,
    output logic [3:0] digit_cnt_o
);

    localparam int unsigned CW = 4 * CODE_LEN;
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CYCLES + 1);
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StUnlocked,
        StProg,
        StLockout
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] buf_q, buf_d;
    logic [CW-1:0] code_q, code_d;
    logic [3:0]    digit_cnt_q, digit_cnt_d;
    logic [FW-1:0] fails_q, fails_d;
    logic [UW-1:0] unlock_tmr_q, unlock_tmr_d;
    logic [LW-1:0] lock_tmr_q, lock_tmr_d;
    logic          fail_q, fail_d;
    logic          unlocked_q, lockout_q, prog_mode_q;

    logic          is_digit, is_set, is_cancel, last_digit;
    logic [CW-1:0] shifted;

    assign is_digit   = key_valid_i && (key_i <= 4'd9);
    assign is_set     = key_valid_i && (key_i == 4'hE);
    assign is_cancel  = key_valid_i && (key_i == 4'hD);
    assign last_digit = (digit_cnt_q == 4'(CODE_LEN - 1));
    // First digit entered ends up in the most significant nibble.
    assign shifted    = (buf_q << 4) | CW'(key_i);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        code_d       = code_q;
        digit_cnt_d  = digit_cnt_q;
        fails_d      = fails_q;
        unlock_tmr_d = unlock_tmr_q;
        lock_tmr_d   = lock_tmr_q;
        fail_d       = 1'b0;

        case (state_q)
            StIdle, StEntry: begin
                if (is_cancel) begin
                    state_d     = StIdle;
                    buf_d       = '0;
                    digit_cnt_d = '0;
                end else if (is_digit) begin
                    if (last_digit) begin
                        buf_d       = '0;
                        digit_cnt_d = '0;
                        if (shifted == code_q) begin
                            state_d      = StUnlocked;
                            fails_d      = '0;
                            unlock_tmr_d = UW'(UNLOCK_CYCLES);
                        end else begin
                            fail_d  = 1'b1;
                            fails_d = fails_q + 1'b1;
                            if (32'(fails_q) + 32'd1 >= MAX_FAILS) begin
                                state_d    = StLockout;
                                lock_tmr_d = LW'(LOCKOUT_CYCLES);
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end else begin
                        state_d     = StEntry;
                        buf_d       = shifted;
                        digit_cnt_d = digit_cnt_q + 4'd1;
                    end
                end
            end
            StUnlocked: begin
                // Keys take priority over timer expiry on the same edge.
                if (is_set) begin
                    state_d      = StProg;
                    unlock_tmr_d = '0;
                end else if (is_cancel) begin
                    state_d      = StIdle;
                    unlock_tmr_d = '0;
                end else if (unlock_tmr_q <= UW'(1)) begin
                    state_d      = StIdle;
                    unlock_tmr_d = '0;
                end else begin
                    unlock_tmr_d = unlock_tmr_q - 1'b1;
                end
            end
            StProg: begin
                if (is_cancel) begin
                    state_d     = StIdle;
                    buf_d       = '0;
                    digit_cnt_d = '0;
                end else if (is_digit) begin
                    if (last_digit) begin
                        state_d     = StIdle;
                        code_d      = shifted;
                        buf_d       = '0;
                        digit_cnt_d = '0;
                    end else begin
                        buf_d       = shifted;
                        digit_cnt_d = digit_cnt_q + 4'd1;
                    end
                end
            end
            StLockout: begin
                if (lock_tmr_q <= LW'(1)) begin
                    state_d    = StIdle;
                    fails_d    = '0;
                    lock_tmr_d = '0;
                end else begin
                    lock_tmr_d = lock_tmr_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            code_q       <= '0;
            digit_cnt_q  <= '0;
            fails_q      <= '0;
            unlock_tmr_q <= '0;
            lock_tmr_q   <= '0;
            fail_q       <= 1'b0;
            unlocked_q   <= 1'b0;
            lockout_q    <= 1'b0;
            prog_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            code_q       <= code_d;
            digit_cnt_q  <= digit_cnt_d;
            fails_q      <= fails_d;
            unlock_tmr_q <= unlock_tmr_d;
            lock_tmr_q   <= lock_tmr_d;
            fail_q       <= fail_d;
            unlocked_q   <= (state_d == StUnlocked);
            lockout_q    <= (state_d == StLockout);
            prog_mode_q  <= (state_d == StProg);
        end
    end

    assign unlocked_o  = unlocked_q;
    assign lockout_o   = lockout_q;
    assign fail_o      = fail_q;
    assign prog_mode_o = prog_mode_q;
    assign digit_cnt_o = digit_cnt_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: expected output changes are queued with their edge index and a
// monitor compares every observed output change against the queue.
module tb_keypad_lock_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [3:0] key   = 4'h0;
    logic       kv_a  = 1'b0;
    logic       kv_b  = 1'b0;

    logic       unl_a, lck_a, fl_a, prg_a;
    logic [3:0] cnt_a;
    logic       unl_b, lck_b, fl_b, prg_b;
    logic [3:0] cnt_b;

    keypad_lock_ctrl u_dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_i       (key),
        .key_valid_i (kv_a),
        .unlocked_o  (unl_a),
        .lockout_o   (lck_a),
        .fail_o      (fl_a),
        .prog_mode_o (prg_a),
        .digit_cnt_o (cnt_a)
    );

    keypad_lock_ctrl #(
        .CODE_LEN      (6),
        .UNLOCK_CYCLES (1)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_i       (key),
        .key_valid_i (kv_b),
        .unlocked_o  (unl_b),
        .lockout_o   (lck_b),
        .fail_o      (fl_b),
        .prog_mode_o (prg_b),
        .digit_cnt_o (cnt_b)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int unsigned t;
        logic [7:0]  v;
    } ev_t;

    ev_t         qa[$];
    ev_t         qb[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  prev_a = 8'h00;
    logic [7:0]  prev_b = 8'h00;
    int unsigned e;

    task automatic check_ev(input bit b, input logic [7:0] v);
        ev_t ev;
        total++;
        if ((b ? qb.size() : qa.size()) == 0) begin
            bad++;
            $display("FAIL dut_%s unexpected change at edge %0d: got %b, required no change",
                     b ? "b" : "a", cyc, v);
        end else begin
            ev = b ? qb.pop_front() : qa.pop_front();
            if (ev.t != cyc || ev.v !== v) begin
                bad++;
                $display("FAIL dut_%s event: got %b at edge %0d, required %b at edge %0d",
                         b ? "b" : "a", v, cyc, ev.v, ev.t);
            end
        end
    endtask

    // Output vector is {unlocked, lockout, fail, prog_mode, digit_cnt}.
    always @(negedge clk) begin
        logic [7:0] va, vb;
        if (mon_en) begin
            va = {unl_a, lck_a, fl_a, prg_a, cnt_a};
            vb = {unl_b, lck_b, fl_b, prg_b, cnt_b};
            if (va !== prev_a) begin
                check_ev(1'b0, va);
                prev_a = va;
            end
            if (vb !== prev_b) begin
                check_ev(1'b1, vb);
                prev_b = vb;
            end
        end
    end

    task automatic expect_ev(input bit b, input int unsigned t, input bit u, input bit l,
                             input bit f, input bit p, input int c);
        ev_t ev;
        ev.t = t;
        ev.v = {u, l, f, p, 4'(c)};
        if (b) qb.push_back(ev);
        else qa.push_back(ev);
    endtask

    // Strobe one key; on return e holds the index of the edge that sampled it.
    task automatic press(input bit b, input logic [3:0] k);
        key = k;
        if (b) kv_b = 1'b1;
        else kv_a = 1'b1;
        @(posedge clk);
        #1;
        e    = cyc;
        kv_a = 1'b0;
        kv_b = 1'b0;
    endtask

    task automatic dig(input bit b, input logic [3:0] k, input bit p, input int c);
        press(b, k);
        expect_ev(b, e, 1'b0, 1'b0, 1'b0, p, c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_edge(input int unsigned t);
        while (cyc + 1 < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input bit b);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        e     = cyc;
        rst_n = 1'b1;
        expect_ev(b, e, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Enter a 4-digit code on dut_a; last digit left to the caller.
    task automatic first3_a(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        dig(1'b0, d0, 1'b0, 1);
        dig(1'b0, d1, 1'b0, 2);
        dig(1'b0, d2, 1'b0, 3);
    endtask

    task automatic unlock_a(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3, input bit with_fall);
        first3_a(d0, d1, d2);
        press(1'b0, d3);
        expect_ev(1'b0, e, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        if (with_fall) expect_ev(1'b0, e + 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic wrong_a(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                           input logic [3:0] d3);
        first3_a(d0, d1, d2);
        press(1'b0, d3);
        expect_ev(1'b0, e, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        expect_ev(1'b0, e + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic first5_b(input logic [3:0] d, input bit p);
        for (int i = 1; i <= 5; i++) dig(1'b1, d, p, i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned eu, el;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if ({unl_a, lck_a, fl_a, prg_a, cnt_a} !== 8'h00) begin
            bad++;
            $display("FAIL reset_a: got %b, required 00000000", {unl_a, lck_a, fl_a, prg_a, cnt_a});
        end
        total++;
        if ({unl_b, lck_b, fl_b, prg_b, cnt_b} !== 8'h00) begin
            bad++;
            $display("FAIL reset_b: got %b, required 00000000", {unl_b, lck_b, fl_b, prg_b, cnt_b});
        end
        mon_en = 1'b1;

        // Default code 0000 unlocks for exactly 5 cycles.
        unlock_a(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        idle(7);

        // Wrong code pulses fail, then the right code unlocks and clears the count.
        wrong_a(4'h0, 4'h0, 4'h0, 4'h1);
        idle(2);
        unlock_a(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        idle(7);

        // Three wrong codes -> 64-cycle lockout; keys ignored, including on the expiry edge.
        wrong_a(4'h1, 4'h1, 4'h1, 4'h1);
        idle(2);
        wrong_a(4'h1, 4'h1, 4'h1, 4'h1);
        idle(2);
        first3_a(4'h1, 4'h1, 4'h1);
        press(1'b0, 4'h1);
        el = e;
        expect_ev(1'b0, el, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        expect_ev(1'b0, el + 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        expect_ev(1'b0, el + 64, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) press(1'b0, 4'h0);
        press(1'b0, 4'hD);
        at_edge(el + 64);
        press(1'b0, 4'h0);
        idle(2);
        unlock_a(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        idle(7);

        // Reprogram to 4719.
        unlock_a(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(1);
        dig(1'b0, 4'hE, 1'b1, 0);
        dig(1'b0, 4'h4, 1'b1, 1);
        dig(1'b0, 4'h7, 1'b1, 2);
        dig(1'b0, 4'h1, 1'b1, 3);
        dig(1'b0, 4'h9, 1'b0, 0);
        idle(2);
        wrong_a(4'h0, 4'h0, 4'h0, 4'h0);
        idle(2);

        // SET on the unlock expiry edge still enters programming; CANCEL leaves it.
        unlock_a(4'h4, 4'h7, 4'h1, 4'h9, 1'b0);
        eu = e;
        at_edge(eu + 5);
        dig(1'b0, 4'hE, 1'b1, 0);
        dig(1'b0, 4'hD, 1'b0, 0);
        idle(2);

        // CANCEL mid-entry, ignored codes and SET mid-entry.
        dig(1'b0, 4'h1, 1'b0, 1);
        dig(1'b0, 4'h2, 1'b0, 2);
        dig(1'b0, 4'hD, 1'b0, 0);
        dig(1'b0, 4'h4, 1'b0, 1);
        press(1'b0, 4'hA);
        dig(1'b0, 4'h7, 1'b0, 2);
        press(1'b0, 4'hF);
        press(1'b0, 4'hE);
        press(1'b0, 4'hB);
        dig(1'b0, 4'h1, 1'b0, 3);
        press(1'b0, 4'h9);
        expect_ev(1'b0, e, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        expect_ev(1'b0, e + 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(7);

        // Reset mid-programming restores passcode 0000.
        unlock_a(4'h4, 4'h7, 4'h1, 4'h9, 1'b0);
        dig(1'b0, 4'hE, 1'b1, 0);
        dig(1'b0, 4'h5, 1'b1, 1);
        dig(1'b0, 4'h6, 1'b1, 2);
        do_reset(1'b0);
        idle(1);
        unlock_a(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        idle(7);

        // CODE_LEN=6, UNLOCK_CYCLES=1 instance.
        first5_b(4'h0, 1'b0);
        press(1'b1, 4'h0);
        expect_ev(1'b1, e, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        expect_ev(1'b1, e + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        first5_b(4'h0, 1'b0);
        press(1'b1, 4'h1);
        expect_ev(1'b1, e, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        expect_ev(1'b1, e + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(2);
        first5_b(4'h0, 1'b0);
        press(1'b1, 4'h0);
        expect_ev(1'b1, e, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        dig(1'b1, 4'hE, 1'b1, 0);
        dig(1'b1, 4'h1, 1'b1, 1);
        dig(1'b1, 4'h2, 1'b1, 2);
        dig(1'b1, 4'h3, 1'b1, 3);
        do_reset(1'b1);
        idle(1);
        first5_b(4'h0, 1'b0);
        press(1'b1, 4'h0);
        expect_ev(1'b1, e, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        expect_ev(1'b1, e + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(4);

        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL drain_a: %0d expected events never seen, required 0", qa.size());
        end
        total++;
        if (qb.size() != 0) begin
            bad++;
            $display("FAIL drain_b: %0d expected events never seen, required 0", qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
